scrolling_message_display: RTL and testbench

- Parametrised successor to the team's 2-bit character decoder: drives NUM_DIGITS active-low 7-segment displays from a writable MSG_LEN-entry character buffer.
- The buffer scrolls circularly across the displays once per prescaler tick, left or right.
- Sits between board switches/keys and the HEX outputs in the lab top levels.

---
 rtl/scroll_disp_pkg.sv | 33 +++
 rtl/char_7seg_decoder.sv | 32 +++
 rtl/scrolling_message_display.sv | 149 ++++++++++++++
 tb/tb_scrolling_message_display.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_disp_pkg.sv
// scroll_disp_pkg: character codes, segment type and reset message shared by
// the scrolling message display and its per-digit decoder.
package scroll_disp_pkg;

    typedef logic [2:0] char_t;
    typedef logic [0:6] seg_t;

    localparam char_t CH_D     = 3'd0;
    localparam char_t CH_E     = 3'd1;
    localparam char_t CH_ONE   = 3'd2;
    localparam char_t CH_ZERO  = 3'd3;
    localparam char_t CH_BLANK = 3'd4;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Message loaded into buffer[0..3] on reset; all later entries are blank.
    localparam int    RST_MSG_LEN = 32'sd4;
    localparam char_t RST_MSG [RST_MSG_LEN] = '{CH_D, CH_E, CH_ONE, CH_ZERO};

    // Reset content of buffer entry idx.
    function automatic char_t rst_char(input int idx);
        char_t c;
        case (idx)
            32'sd0:  c = RST_MSG[0];
            32'sd1:  c = RST_MSG[1];
            32'sd2:  c = RST_MSG[2];
            32'sd3:  c = RST_MSG[3];
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/char_7seg_decoder.sv
// char_7seg_decoder: maps a 3-bit character code to active-low segments a..g,
// index 0 of the output being segment a.
module char_7seg_decoder
    import scroll_disp_pkg::*;
(
    input  char_t ch,
    output seg_t  seg
);

    // Patterns are written g..a, so bit 0 of pat_s is segment a.
    logic [6:0] pat_s;

    // Character code to segment pattern lookup.
    always_comb begin
        case (ch)
            CH_D:    pat_s = 7'b0100001;
            CH_E:    pat_s = 7'b0000110;
            CH_ONE:  pat_s = 7'b1111001;
            CH_ZERO: pat_s = 7'b1000000;
            default: pat_s = 7'b1111111;
        endcase
    end

    // Copy bit-for-bit so that seg[0] (segment a) equals pat_s[0].
    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 7; i++) begin
            seg[i] = pat_s[i];
        end
    end

endmodule

// File: rtl/scrolling_message_display.sv
// scrolling_message_display: scrolls a writable MSG_LEN-entry character buffer
// circularly across NUM_DIGITS active-low 7-segment displays, one step per
// TICK_DIV clock cycles. Optional macro SCROLL_BLINK_EN adds a blink phase
// that blanks all digits on alternate scroll steps while blink is high.
module scrolling_message_display
    import scroll_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scroll_en,
    input  logic                        dir,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
    input  char_t                       wr_data,
    input  logic                        blink,
    output seg_t [NUM_DIGITS-1:0]       hex_n,
    output logic [$clog2(MSG_LEN)-1:0]  pos,
    output logic                        tick
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_r;
    logic          cnt_last_s;
    logic          step_s;
    logic [AW-1:0] pos_next_s;
    logic          wr_ok_s;
    char_t         buf_r [MSG_LEN];
    seg_t          seg_s [NUM_DIGITS];

    assign cnt_last_s = (cnt_r == CW'(TICK_DIV - 1));
    assign step_s     = scroll_en & cnt_last_s;
    // Widen by one bit so the range test also works when MSG_LEN is a power of two.
    assign wr_ok_s    = wr_en & ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN));

    // Prescaler counts 0..TICK_DIV-1 while enabled; tick marks each scroll step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            tick  <= 1'b0;
        end else if (scroll_en) begin
            if (cnt_last_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            tick <= cnt_last_s;
        end else begin
            tick <= 1'b0;
        end
    end

    // Next position with explicit wrap, since MSG_LEN need not be a power of two.
    always_comb begin
        pos_next_s = pos;
        if (dir == 1'b0) begin
            if (pos == AW'(MSG_LEN - 1)) begin
                pos_next_s = {AW{1'b0}};
            end else begin
                pos_next_s = pos + AW'(1);
            end
        end else begin
            if (pos == {AW{1'b0}}) begin
                pos_next_s = AW'(MSG_LEN - 1);
            end else begin
                pos_next_s = pos - AW'(1);
            end
        end
    end

    // Scroll position advances in the same cycle the tick pulse is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= {AW{1'b0}};
        end else if (step_s) begin
            pos <= pos_next_s;
        end
    end

    // Message buffer: reset message, then one write per cycle to in-range entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buf_r[i] <= rst_char(i);
            end
        end else if (wr_ok_s) begin
            buf_r[wr_addr] <= wr_data;
        end
    end

    // Digit k shows buffer[(pos + NUM_DIGITS-1-k) mod MSG_LEN]; the sum is
    // below 2*MSG_LEN so a single conditional subtract suffices.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [AW:0]   sum_s;
        logic [AW-1:0] idx_s;

        // Wrapped buffer index for this digit.
        always_comb begin
            sum_s = {1'b0, pos} + (AW + 1)'(NUM_DIGITS - 1 - k);
            if (sum_s >= (AW + 1)'(MSG_LEN)) begin
                idx_s = AW'(sum_s - (AW + 1)'(MSG_LEN));
            end else begin
                idx_s = sum_s[AW-1:0];
            end
        end

        char_7seg_decoder u_dec (
            .ch  (buf_r[idx_s]),
            .seg (seg_s[k])
        );
    end

`ifdef SCROLL_BLINK_EN
    logic phase_r;

    // Blink phase flips on every scroll step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 1'b0;
        end else if (step_s) begin
            phase_r <= ~phase_r;
        end
    end
`else
    logic unused_blink_s;
    assign unused_blink_s = blink;
`endif

    // Registered display: follows buffer/pos one cycle after any change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_n <= {NUM_DIGITS{SEG_BLANK}};
`ifdef SCROLL_BLINK_EN
        end else if (blink && phase_r) begin
            hex_n <= {NUM_DIGITS{SEG_BLANK}};
`endif
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_n[k] <= seg_s[k];
            end
        end
    end

endmodule

// File: tb/tb_scrolling_message_display.sv
// Bench for scrolling_message_display: a cycle model pushes expected outputs
// into a scoreboard queue at each rising edge and they are compared on the
// falling edge; directed checks cover the boundary cases. A second instance
// with MSG_LEN=5 exercises non-power-of-two wrap and out-of-range writes.
`timescale 1ns/1ps
module tb_scrolling_message_display;
    import scroll_disp_pkg::*;

    localparam int ND  = 4;
    localparam int ML  = 8;
    localparam int TD  = 4;
    localparam int BND = 3;
    localparam int BML = 5;
    localparam int BTD = 2;

    logic clk = 1'b0;
    logic rst;
    logic scroll_en, dir, wr_en, blink;
    logic [2:0] wr_addr;
    char_t      wr_data;
    logic [ND-1:0][0:6] hex_a;
    logic [2:0] pos_a;
    logic       tick_a;

    logic b_scroll_en, b_dir, b_wr_en;
    logic [2:0] b_wr_addr;
    char_t      b_wr_data;
    logic [BND-1:0][0:6] hex_b;
    logic [2:0] pos_b;
    logic       tick_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scrolling_message_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut_a (
        .clk(clk), .rst(rst), .scroll_en(scroll_en), .dir(dir), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .blink(blink),
        .hex_n(hex_a), .pos(pos_a), .tick(tick_a)
    );

    scrolling_message_display #(.NUM_DIGITS(BND), .MSG_LEN(BML), .TICK_DIV(BTD)) dut_b (
        .clk(clk), .rst(rst), .scroll_en(b_scroll_en), .dir(b_dir), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .blink(1'b0),
        .hex_n(hex_b), .pos(pos_b), .tick(tick_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Segment table, written g..a (bit 0 = segment a, active-low).
    function automatic logic [6:0] pat(input logic [2:0] c);
        case (c)
            3'd0:    return 7'b0100001;
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1111001;
            3'd3:    return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [0:6] seg_of(input logic [2:0] c);
        logic [6:0] p;
        logic [0:6] s;
        p = pat(c);
        for (int i = 0; i < 7; i++) s[i] = p[i];
        return s;
    endfunction

    function automatic logic [3:0][0:6] hex4(input logic [2:0] c3, input logic [2:0] c2,
                                             input logic [2:0] c1, input logic [2:0] c0);
        logic [3:0][0:6] v;
        v[3] = seg_of(c3); v[2] = seg_of(c2); v[1] = seg_of(c1); v[0] = seg_of(c0);
        return v;
    endfunction

    function automatic logic [2:0][0:6] hex3(input logic [2:0] c2, input logic [2:0] c1,
                                             input logic [2:0] c0);
        logic [2:0][0:6] v;
        v[2] = seg_of(c2); v[1] = seg_of(c1); v[0] = seg_of(c0);
        return v;
    endfunction

    // ---------------- reference model and scoreboard for dut_a ----------------
    typedef struct packed {
        logic [27:0] hex;
        logic [2:0]  pos;
        logic        tick;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] m_buf [ML];
    int         m_cnt;
    int         m_pos;
    logic       m_phase;

    always @(posedge clk) begin : model
        automatic exp_t e;
        automatic logic [ND-1:0][0:6] h;
        automatic logic last;
        if (rst) begin
            m_buf   <= '{CH_D, CH_E, CH_ONE, CH_ZERO, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
            m_cnt   <= 0;
            m_pos   <= 0;
            m_phase <= 1'b0;
            sb_q.delete();
        end else begin
            for (int k = 0; k < ND; k++) h[k] = seg_of(m_buf[(m_pos + ND - 1 - k) % ML]);
`ifdef SCROLL_BLINK_EN
            if (blink && m_phase) h = '1;
`endif
            last   = (m_cnt == TD - 1);
            e.tick = scroll_en && last;
            e.hex  = h;
            e.pos  = 3'(e.tick ? (dir ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML) : m_pos);
            if (scroll_en) m_cnt <= last ? 0 : m_cnt + 1;
            if (e.tick) begin
                m_pos   <= int'(e.pos);
                m_phase <= ~m_phase;
            end
            if (wr_en && int'(wr_addr) < ML) m_buf[wr_addr] <= wr_data;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin : sb_check
        exp_t e;
        if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_hex",  32'(hex_a),  32'(e.hex));
            check_eq("sb_pos",  32'(pos_a),  32'(e.pos));
            check_eq("sb_tick", 32'(tick_a), 32'(e.tick));
        end
    end

    // Wait (bounded) for a tick from dut_a (which=0) or dut_b (which=1).
    task automatic wait_tick(input int which, output int cyc);
        logic tk;
        cyc = 0;
        tk  = 1'b0;
        while (!tk && cyc < 64) begin
            @(negedge clk);
            cyc++;
            tk = (which == 0) ? tick_a : tick_b;
        end
        if (which == 0) check_eq("tick_a_seen", 32'(tk), 32'd1);
        else            check_eq("tick_b_seen", 32'(tk), 32'd1);
    endtask

    initial begin : stim
        int cyc;
        int ticks;
        rst = 1'b1;
        scroll_en = 1'b0; dir = 1'b0; wr_en = 1'b0; blink = 1'b0;
        wr_addr = 3'd0; wr_data = CH_D;
        b_scroll_en = 1'b0; b_dir = 1'b0; b_wr_en = 1'b0; b_wr_addr = 3'd0; b_wr_data = CH_D;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_hex_a",  32'(hex_a),  32'h0FFF_FFFF);
        check_eq("rst_pos_a",  32'(pos_a),  32'd0);
        check_eq("rst_tick_a", 32'(tick_a), 32'd0);
        check_eq("rst_hex_b",  32'(hex_b),  32'h001F_FFFF);
        rst = 1'b0;
        @(negedge clk);
        check_eq("msg_after_rst",   32'(hex_a), 32'(hex4(CH_D, CH_E, CH_ONE, CH_ZERO)));
        check_eq("msg_after_rst_b", 32'(hex_b), 32'(hex3(CH_D, CH_E, CH_ONE)));

        // Scroll left through a full wrap
        scroll_en = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wait_tick(0, cyc);
            if (i != 7) check_eq("tick_period", 32'(cyc), 32'(TD));
            check_eq("pos_left", 32'(pos_a), 32'(i % ML));
            if (i == 6) begin
                @(negedge clk);
                check_eq("hex_pos6", 32'(hex_a), 32'(hex4(CH_BLANK, CH_BLANK, CH_D, CH_E)));
            end
        end

        // Reverse direction from pos 0
        dir = 1'b1;
        wait_tick(0, cyc);
        check_eq("pos_right_wrap", 32'(pos_a), 32'd7);
        @(negedge clk);
        check_eq("hex_pos7", 32'(hex_a), 32'(hex4(CH_BLANK, CH_D, CH_E, CH_ONE)));

        // Frozen
        scroll_en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick_a) ticks++;
        end
        check_eq("frozen_ticks", 32'(ticks), 32'd0);
        check_eq("frozen_pos",   32'(pos_a), 32'd7);

        // Write coinciding with a step
        scroll_en = 1'b1;
        wait_tick(0, cyc);
        check_eq("pos_6", 32'(pos_a), 32'd6);
        repeat (TD - 1) @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = CH_ZERO;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("tick_with_write", 32'(tick_a), 32'd1);
        check_eq("pos_with_write",  32'(pos_a),  32'd5);
        @(negedge clk);
        check_eq("hex_write_step", 32'(hex_a), 32'(hex4(CH_ZERO, CH_BLANK, CH_BLANK, CH_D)));

        // Asynchronous reset mid-scroll (pos 5, prescaler at 2)
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_hex",  32'(hex_a),  32'h0FFF_FFFF);
        check_eq("async_rst_pos",  32'(pos_a),  32'd0);
        check_eq("async_rst_tick", 32'(tick_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) wait_tick(0, cyc);
        check_eq("pos_after_rst", 32'(pos_a), 32'd5);
        @(negedge clk);
        check_eq("buf_cleared", 32'(hex_a), 32'(hex4(CH_BLANK, CH_BLANK, CH_BLANK, CH_D)));

        // Blink request (phase is 1 after three steps since reset)
        blink = 1'b1;
        @(negedge clk);
`ifdef SCROLL_BLINK_EN
        check_eq("blink_hex", 32'(hex_a), 32'h0FFF_FFFF);
`else
        check_eq("blink_hex", 32'(hex_a), 32'(hex4(CH_BLANK, CH_BLANK, CH_BLANK, CH_D)));
`endif
        wait_tick(0, cyc);
        wait_tick(0, cyc);
        blink = 1'b0;
        repeat (2) @(negedge clk);
        scroll_en = 1'b0;
        repeat (2) @(negedge clk);

        // dut_b: MSG_LEN=5, out-of-range writes, last-entry write, wrap
        b_wr_en = 1'b1; b_wr_addr = 3'd6; b_wr_data = CH_ZERO;
        @(negedge clk);
        b_wr_addr = 3'd7;
        @(negedge clk);
        b_wr_addr = 3'd4; b_wr_data = CH_ONE;
        @(negedge clk);
        b_wr_en = 1'b0;
        @(negedge clk);
        check_eq("b_oob_write", 32'(hex_b), 32'(hex3(CH_D, CH_E, CH_ONE)));
        b_scroll_en = 1'b1; b_dir = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wait_tick(1, cyc);
            check_eq("b_pos_left", 32'(pos_b), 32'(i % BML));
            if (i == 3) begin
                @(negedge clk);
                check_eq("b_hex_pos3", 32'(hex_b), 32'(hex3(CH_ZERO, CH_ONE, CH_D)));
            end
            if (i == 4) begin
                @(negedge clk);
                check_eq("b_hex_pos4", 32'(hex_b), 32'(hex3(CH_ONE, CH_D, CH_E)));
            end
        end
        b_dir = 1'b1;
        wait_tick(1, cyc);
        check_eq("b_pos_right_wrap", 32'(pos_b), 32'd4);
        b_scroll_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
